// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM output stage: default widths, the reset period
// top and the controller state encoding.
package pwm_pkg;

  // Default width of the period top word; the period is top+1 clocks.
  localparam int DEF_TOP_W = 8;

  // Compare is one bit wider than top so that compare = top+1 gives 100% duty.
  localparam int DEF_CMP_W = DEF_TOP_W + 1;

  // Period top loaded at reset, before the sequencer has sent a real one.
  localparam logic [DEF_TOP_W-1:0] RST_TOP = 8'hFF;

  // IDLE waits for the first top and compare words; RUN generates the waveform.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage : pwm_pkg

// File: rtl/pwm_shadow_reg.sv
// Double-buffered configuration register. A load strobe parks the incoming word
// in a pending slot; the pending word moves to the active slot only when the
// owner opens a commit window, so the active value never changes mid-period.
// A load that lands inside the commit window bypasses the pending slot.
module pwm_shadow_reg #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic         commit,
  input  logic         bypass,
  output logic [W-1:0] active,
  output logic         seen,
  output logic         committed
);

  logic [W-1:0] pending_q;
  logic         pending_flag_q;
  logic         take_bypass;
  logic         take_pending;

  // An incoming word inside the window is newer than anything pending, so it
  // wins and goes straight to the active slot.
  assign take_bypass  = bypass && load;
  assign take_pending = commit && pending_flag_q && !take_bypass;
  assign committed    = take_bypass || take_pending;

  // Pending/active update and the "word received since reset" flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      active         <= RST_VAL;
      // NOTE: the pending word is reset as well as its flag; it is one word,
      // not a memory array, and a known value keeps simulation X-free.
      pending_q      <= '0;
      pending_flag_q <= 1'b0;
      seen           <= 1'b0;
    end else begin
      if (load) begin
        seen <= 1'b1;
      end
      if (take_bypass) begin
        active         <= data;
        pending_flag_q <= 1'b0;
      end else begin
        if (take_pending) begin
          active <= pending_q;
        end
        // Last write wins: a new strobe simply overwrites the pending slot.
        if (load) begin
          pending_q      <= data;
          pending_flag_q <= 1'b1;
        end else if (commit) begin
          pending_flag_q <= 1'b0;
        end
      end
    end
  end

endmodule : pwm_shadow_reg

// File: rtl/pwm_generator.sv
// Single-channel PWM output stage between the PWM sequencer and an LED/IO pin.
// A free-running counter walks 0..top; the output is high while count < compare.
// Top and compare are double-buffered and only take effect at a period boundary
// (or while the channel is idle or disabled), so the pin never glitches.
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int TOP_W = DEF_TOP_W,
  parameter int CMP_W = TOP_W + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic [TOP_W-1:0] i_top,
  input  logic             i_top_valid,
  input  logic [CMP_W-1:0] i_compare,
  input  logic             i_compare_valid,
  output logic             o_pwm,
  output logic             o_period_end,
  output logic             o_commit,
  output logic             o_running
);

  state_t           state_q;
  state_t           state_d;

  logic [TOP_W-1:0] count_q;
  logic [TOP_W-1:0] active_top;
  logic [CMP_W-1:0] active_cmp;

  logic             seen_top;
  logic             seen_cmp;
  logic             committed_top;
  logic             committed_cmp;

  logic             run_en;
  logic             at_top;
  logic             commit_win;
  logic             both_ready;
  logic             pwm_q;
  logic             commit_q;

  // Period top: starts at the reset top so the counter is bounded before the
  // sequencer has configured the channel.
  pwm_shadow_reg #(
    .W       (TOP_W),
    .RST_VAL (TOP_W'(RST_TOP))
  ) u_top_reg (
    .clk       (i_clk),
    .rst       (i_rst),
    .load      (i_top_valid),
    .data      (i_top),
    .commit    (commit_win),
    .bypass    (commit_win),
    .active    (active_top),
    .seen      (seen_top),
    .committed (committed_top)
  );

  // Compare threshold: zero at reset, i.e. output low.
  pwm_shadow_reg #(
    .W       (CMP_W),
    .RST_VAL ('0)
  ) u_cmp_reg (
    .clk       (i_clk),
    .rst       (i_rst),
    .load      (i_compare_valid),
    .data      (i_compare),
    .commit    (commit_win),
    .bypass    (commit_win),
    .active    (active_cmp),
    .seen      (seen_cmp),
    .committed (committed_cmp)
  );

  // Same-cycle strobes count as received, so RUN can start on that very edge.
  assign both_ready = (seen_top || i_top_valid) && (seen_cmp || i_compare_valid);
  assign at_top     = (count_q == active_top);

  // State register.
  always_ff @(posedge i_clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of block order.
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: leave IDLE once both words are known; RUN is left only by reset.
  always_comb begin
    // NOTE: default first, so no path through the case leaves state_d
    // unassigned and no latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (both_ready) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // State-decoded controls: counting enable, period end and the commit window.
  always_comb begin
    o_running    = (state_q == ST_RUN);
    run_en       = o_running && i_enable;
    o_period_end = run_en && at_top;
    // Words may land whenever the waveform is not being produced, or exactly at
    // the boundary where the counter wraps to 0.
    commit_win   = !run_en || at_top;
  end

  // Period counter: held at 0 unless running and enabled, wraps after active top.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= '0;
    end else if (!run_en || at_top) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + TOP_W'(1);
    end
  end

  // Registered output and commit pulse. The comparison uses the compare value
  // active in the same cycle as the count, with count zero-extended.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pwm_q    <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      pwm_q    <= run_en && (CMP_W'(count_q) < active_cmp);
      // Commits done while IDLE are part of start-up and are not reported.
      commit_q <= o_running && (committed_top || committed_cmp);
    end
  end

  assign o_pwm    = pwm_q;
  assign o_commit = commit_q;

endmodule : pwm_generator

// File: tb/tb_pwm_generator.sv
// Scoreboard bench for pwm_generator. Stimulus pushes the expected shape of each
// PWM period (length, high clocks, commit pulse at its end); a monitor rebuilds
// each period from the pins and compares it with the head of the queue.
module tb_pwm_generator;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_enable = 1'b1;
  logic [7:0] i_top = '0;
  logic       i_top_valid = 1'b0;
  logic [8:0] i_compare = '0;
  logic       i_compare_valid = 1'b0;
  logic       o_pwm;
  logic       o_period_end;
  logic       o_commit;
  logic       o_running;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int len;
    int hi;
    int cmt;
  } rec_t;

  rec_t exp_q[$];

  pwm_generator dut (
    .i_clk           (clk),
    .i_rst           (i_rst),
    .i_enable        (i_enable),
    .i_top           (i_top),
    .i_top_valid     (i_top_valid),
    .i_compare       (i_compare),
    .i_compare_valid (i_compare_valid),
    .o_pwm           (o_pwm),
    .o_period_end    (o_period_end),
    .o_commit        (o_commit),
    .o_running       (o_running)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int len, input int hi, input int cmt, input int n);
    rec_t r;
    r.len = len;
    r.hi  = hi;
    r.cmt = cmt;
    for (int i = 0; i < n; i++) exp_q.push_back(r);
  endtask

  // Drive strobes at a negedge; they are sampled by the following posedge.
  task automatic strobe(input bit do_top, input logic [7:0] t,
                        input bit do_cmp, input logic [8:0] c);
    i_top           = t;
    i_top_valid     = do_top;
    i_compare       = c;
    i_compare_valid = do_cmp;
  endtask

  task automatic end_strobe();
    @(negedge clk);
    i_top_valid     = 1'b0;
    i_compare_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("scoreboard drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_pe(input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_period_end) begin
        found = 1'b1;
        break;
      end
    end
    check("period_end seen", int'(found), 1);
  endtask

  // Monitor: o_pwm in a cycle reflects the count of the previous cycle, so high
  // clocks are attributed one cycle back and a period is closed one cycle after
  // its o_period_end, which is also when its commit pulse is visible.
  int hi_acc = 0;
  int len_acc = 0;
  int len_done = 0;
  bit pe_d = 1'b0;
  bit run_d = 1'b0;

  always @(negedge clk) begin
    rec_t e;
    if (!o_running) begin
      hi_acc  = 0;
      len_acc = 0;
      pe_d    = 1'b0;
      run_d   = 1'b0;
    end else begin
      if (run_d && o_pwm) hi_acc++;
      if (pe_d) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("period length", len_done, e.len);
          check("period high clocks", hi_acc, e.hi);
          check("commit pulse at period end", int'(o_commit), e.cmt);
        end
        hi_acc = 0;
      end
      len_acc++;
      if (o_period_end) begin
        len_done = len_acc;
        len_acc  = 0;
      end
      pe_d  = o_period_end;
      run_d = 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("reset o_pwm", int'(o_pwm), 0);
    check("reset o_period_end", int'(o_period_end), 0);
    check("reset o_commit", int'(o_commit), 0);
    check("reset o_running", int'(o_running), 0);
    i_rst = 1'b0;

    // 1: top=FF, cmp=7F together -> 256-clk periods, 127 high.
    @(negedge clk);
    strobe(1'b1, 8'hFF, 1'b1, 9'h07F);
    #1 push(256, 127, 0, 2);
    end_strobe();
    check("running after first words", int'(o_running), 1);
    wait_drain(700);

    // 2: cmp=40 mid-period -> current period unchanged, commit at its end, then 64 high.
    repeat (100) @(negedge clk);
    strobe(1'b0, 8'h00, 1'b1, 9'h040);
    #1 begin
      push(256, 127, 1, 1);
      push(256, 64, 0, 1);
    end
    end_strobe();
    wait_drain(700);

    // 3a: top=0 -> after the current period, a period_end every clock.
    repeat (50) @(negedge clk);
    strobe(1'b1, 8'h00, 1'b0, 9'h000);
    #1 begin
      push(256, 64, 1, 1);
      push(1, 1, 0, 4);
    end
    end_strobe();
    wait_drain(700);

    // 3b: cmp=0 -> constant low.
    @(negedge clk);
    strobe(1'b0, 8'h00, 1'b1, 9'h000);
    #1 begin
      push(1, 1, 1, 1);
      push(1, 0, 0, 4);
    end
    end_strobe();
    wait_drain(50);

    // 3c: cmp=1FF -> constant high.
    @(negedge clk);
    strobe(1'b0, 8'h00, 1'b1, 9'h1FF);
    #1 begin
      push(1, 0, 1, 1);
      push(1, 1, 0, 4);
    end
    end_strobe();
    wait_drain(50);

    // Back to a 256-clk period with 128 high.
    @(negedge clk);
    strobe(1'b1, 8'hFF, 1'b1, 9'h080);
    #1 begin
      push(1, 1, 1, 1);
      push(256, 128, 0, 1);
    end
    end_strobe();
    wait_drain(700);

    // 4: cmp=20 then cmp=30 in one period -> only 30 (48 high), one commit.
    repeat (10) @(negedge clk);
    strobe(1'b0, 8'h00, 1'b1, 9'h020);
    #1 begin
      push(256, 128, 1, 1);
      push(256, 48, 0, 1);
    end
    end_strobe();
    repeat (10) @(negedge clk);
    strobe(1'b0, 8'h00, 1'b1, 9'h030);
    end_strobe();
    wait_drain(700);

    // 5: top=0F on the period-end cycle -> 16-clk period starts at once; cmp 48 > 15 is all high.
    wait_pe(300);
    strobe(1'b1, 8'h0F, 1'b0, 9'h000);
    #1 begin
      push(256, 48, 1, 1);
      push(16, 16, 0, 2);
    end
    end_strobe();
    wait_drain(400);

    // cmp=5 mid-period in the 16-clk regime.
    repeat (3) @(negedge clk);
    strobe(1'b0, 8'h00, 1'b1, 9'h005);
    #1 begin
      push(16, 16, 1, 1);
      push(16, 5, 0, 1);
    end
    end_strobe();
    wait_drain(100);

    // 6: drop enable mid-period while the output is high.
    wait_pe(40);
    repeat (2) @(negedge clk);
    check("pwm high before disable", int'(o_pwm), 1);
    i_enable = 1'b0;
    @(negedge clk);
    check("pwm low after disable", int'(o_pwm), 0);
    for (int i = 0; i < 16; i++) begin
      check("no period_end while disabled", int'(o_period_end), 0);
      check("pwm low while disabled", int'(o_pwm), 0);
      if (i == 4) strobe(1'b0, 8'h00, 1'b1, 9'h008);
      if (i == 5) strobe(1'b0, 8'h00, 1'b0, 9'h000);
      @(negedge clk);
    end
    // Re-enable: period restarts at 0 with the compare committed while disabled.
    i_enable = 1'b1;
    repeat (20) @(negedge clk);
    push(16, 8, 0, 2);
    wait_drain(100);

    // Reset mid-run: everything drops, IDLE until both words are sent again.
    repeat (5) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    check("mid-run reset o_pwm", int'(o_pwm), 0);
    check("mid-run reset o_period_end", int'(o_period_end), 0);
    check("mid-run reset o_commit", int'(o_commit), 0);
    check("mid-run reset o_running", int'(o_running), 0);
    i_rst = 1'b0;
    @(negedge clk);
    strobe(1'b1, 8'h03, 1'b0, 9'h000);
    end_strobe();
    repeat (8) @(negedge clk);
    check("idle with top only o_running", int'(o_running), 0);
    check("idle with top only o_pwm", int'(o_pwm), 0);
    strobe(1'b0, 8'h00, 1'b1, 9'h002);
    #1 push(4, 2, 0, 3);
    end_strobe();
    check("running after both words resent", int'(o_running), 1);
    wait_drain(50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_pwm_generator
